cordic_arbiter: RTL and testbench

- Shares one CORDIC unit (circular, linear or hyperbolic mode) between NREQ feature-extraction requesters, e.g. the statistical-feature path and the gradient/entropy path.
- Replaces the per-path CORDIC instances.
- Grants requesters round-robin, drives the CORDIC operand and mode inputs, waits a fixed latency, then returns result and z to the granted requester with a one-cycle done strobe.

---
 rtl/cordic_arbiter.sv | 153 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that time-shares one CORDIC unit between NREQ requesters.
// Operands are latched at the grant edge; result and z are captured after LAT cycles.
module cordic_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int MW   = 2,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] op_x,
  input  logic [NREQ*DW-1:0] op_y,
  input  logic [NREQ*MW-1:0] op_mode,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     res_out,
  output logic [DW-1:0]     z_out,
  output logic [2:0]        gnt_id,
  output logic              busy,
  output logic [DW-1:0]     c_in1,
  output logic [DW-1:0]     c_in2,
  output logic [MW-1:0]     c_mode,
  input  logic [DW-1:0]     c_result,
  input  logic [DW-1:0]     c_z,
  output logic              state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Handshake: req is a level held with its operands until the one-cycle gnt
  // pulse; operands are sampled only on that edge. done is a one-cycle pulse
  // to the same requester when res_out/z_out are valid; they hold until the
  // next completion. busy spans the grant cycle through the done cycle.

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic [DW-1:0]   res_d, z_d, cin1_d, cin2_d;
  logic [MW-1:0]   cmode_d;
  logic [2:0]      gnt_id_d;
  logic            busy_d;

  logic [DW-1:0]   x_arr    [NREQ];
  logic [DW-1:0]   y_arr    [NREQ];
  logic [MW-1:0]   mode_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i]    = op_x[i*DW +: DW];
    assign y_arr[i]    = op_y[i*DW +: DW];
    assign mode_arr[i] = op_mode[i*MW +: MW];
  end

  // Rotating scan starting at ptr; the first set request wins.
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = (scan == IW'(NREQ - 1)) ? '0 : scan + IW'(1);
    end
  end

  logic [IW-1:0] cur_w;
  assign cur_w = gnt_id[IW-1:0];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    res_d    = res_out;
    z_d      = z_out;
    gnt_id_d = gnt_id;
    busy_d   = busy;
    cin1_d   = c_in1;
    cin2_d   = c_in2;
    cmode_d  = c_mode;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (win_found) begin
          cin1_d   = x_arr[win_idx];
          cin2_d   = y_arr[win_idx];
          cmode_d  = mode_arr[win_idx];
          gnt_d    = NREQ'(1) << win_idx;
          gnt_id_d = 3'(win_idx);
          busy_d   = 1'b1;
          cnt_d    = 4'(LAT - 1);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // busy stays high through the done cycle and drops back in IDLE.
          res_d   = c_result;
          z_d     = c_z;
          done_d  = NREQ'(1) << cur_w;
          ptr_d   = (cur_w == IW'(NREQ - 1)) ? '0 : cur_w + IW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      done    <= '0;
      res_out <= '0;
      z_out   <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      c_in1   <= '0;
      c_in2   <= '0;
      c_mode  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      done    <= done_d;
      res_out <= res_d;
      z_out   <= z_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      c_in1   <= cin1_d;
      c_in2   <= cin2_d;
      c_mode  <= cmode_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: a LAT=1 and a LAT=4 instance, each driving
// an adder/subtractor CORDIC stub, checked with immediate assertions.
module tb_cordic_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MW   = 2;

  logic clk;
  logic nReset;

  // LAT=1 instance
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] op_x, op_y;
  logic [NREQ*MW-1:0] op_mode;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      res_out, z_out, c_in1, c_in2, c_result, c_z;
  logic [2:0]         gnt_id;
  logic               busy, state_dbg;
  logic [MW-1:0]      c_mode;

  // LAT=4 instance
  logic [NREQ-1:0]    req4;
  logic [NREQ*DW-1:0] op_x4, op_y4;
  logic [NREQ*MW-1:0] op_mode4;
  logic [NREQ-1:0]    gnt4, done4;
  logic [DW-1:0]      res_out4, z_out4, c_in1_4, c_in2_4, c_result4, c_z4;
  logic [2:0]         gnt_id4;
  logic               busy4, state_dbg4;
  logic [MW-1:0]      c_mode4;

  int n_cmp = 0;
  int n_err = 0;

  assign c_result  = c_in1 + c_in2;
  assign c_z       = c_in1 - c_in2;
  assign c_result4 = c_in1_4 + c_in2_4;
  assign c_z4      = c_in1_4 - c_in2_4;

  cordic_arbiter #(.NREQ(NREQ), .DW(DW), .MW(MW), .LAT(1)) u_dut (
    .clk(clk), .nReset(nReset), .req(req), .op_x(op_x), .op_y(op_y),
    .op_mode(op_mode), .gnt(gnt), .done(done), .res_out(res_out),
    .z_out(z_out), .gnt_id(gnt_id), .busy(busy), .c_in1(c_in1),
    .c_in2(c_in2), .c_mode(c_mode), .c_result(c_result), .c_z(c_z),
    .state_dbg(state_dbg)
  );

  cordic_arbiter #(.NREQ(NREQ), .DW(DW), .MW(MW), .LAT(4)) u_dut4 (
    .clk(clk), .nReset(nReset), .req(req4), .op_x(op_x4), .op_y(op_y4),
    .op_mode(op_mode4), .gnt(gnt4), .done(done4), .res_out(res_out4),
    .z_out(z_out4), .gnt_id(gnt_id4), .busy(busy4), .c_in1(c_in1_4),
    .c_in2(c_in2_4), .c_mode(c_mode4), .c_result(c_result4), .c_z(c_z4),
    .state_dbg(state_dbg4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [MW-1:0] m);
    op_x[i*DW +: DW]    = x;
    op_y[i*DW +: DW]    = y;
    op_mode[i*MW +: MW] = m;
  endtask

  task automatic set_op4(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [MW-1:0] m);
    op_x4[i*DW +: DW]    = x;
    op_y4[i*DW +: DW]    = y;
    op_mode4[i*MW +: MW] = m;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nReset = 1'b0;
    req = '0; op_x = '0; op_y = '0; op_mode = '0;
    req4 = '0; op_x4 = '0; op_y4 = '0; op_mode4 = '0;
    tick();
    tick();

    // reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res", res_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_c_in1", c_in1, 0);
    chk("rst_c_mode", 32'(c_mode), 0);
    chk("rst_state", 32'(state_dbg), 0);
    nReset = 1'b1;

    // single request
    set_op(0, 10, 3, 2'd1);
    req = 4'b0001;
    tick();
    chk("s_gnt", 32'(gnt), 32'b0001);
    chk("s_gnt_id", 32'(gnt_id), 0);
    chk("s_busy_g", 32'(busy), 1);
    chk("s_c_in1", c_in1, 10);
    chk("s_c_in2", c_in2, 3);
    chk("s_c_mode", 32'(c_mode), 1);
    chk("s_done_early", 32'(done), 0);
    req = 4'b0000;
    tick();
    chk("s_done", 32'(done), 32'b0001);
    chk("s_res", res_out, 13);
    chk("s_z", z_out, 7);
    chk("s_busy_d", 32'(busy), 1);
    chk("s_gnt_off", 32'(gnt), 0);
    tick();
    chk("s_done_off", 32'(done), 0);
    chk("s_busy_off", 32'(busy), 0);
    chk("s_res_hold", res_out, 13);

    // reset pulse puts the pointer back to 0
    nReset = 1'b0;
    tick();
    nReset = 1'b1;

    // all four requesting: strict rotation 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(256 * (i + 1)), 32'(i + 1), 2'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int id;
      id = k % NREQ;
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << id);
      chk("rr_gnt_id", 32'(gnt_id), 32'(id));
      tick();
      chk("rr_done", 32'(done), 32'(1) << id);
      chk("rr_res", res_out, 32'(256 * (id + 1) + id + 1));
      chk("rr_gnt_off", 32'(gnt), 0);
      if (k == 4) req = 4'b0000;
    end

    // pointer skip: serve 1, then 0 wraps past 2,3, then 1100 picks 2
    req = 4'b0010;
    tick();
    chk("ps_gnt1", 32'(gnt), 32'b0010);
    req = 4'b0000;
    tick();
    chk("ps_done1", 32'(done), 32'b0010);
    req = 4'b0001;
    tick();
    chk("ps_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick();
    chk("ps_done0", 32'(done), 32'b0001);
    req = 4'b1100;
    tick();
    chk("ps_gnt2", 32'(gnt), 32'b0100);
    chk("ps_gnt_id2", 32'(gnt_id), 2);
    req = 4'b0000;
    tick();
    chk("ps_done2", 32'(done), 32'b0100);

    // operand capture: operands changed after grant must not leak in
    set_op(1, 5, 0, 2'd2);
    req = 4'b0010;
    tick();
    chk("oc_gnt", 32'(gnt), 32'b0010);
    chk("oc_c_in1", c_in1, 5);
    set_op(1, 99, 0, 2'd2);
    req = 4'b0000;
    tick();
    chk("oc_done", 32'(done), 32'b0010);
    chk("oc_res", res_out, 5);
    chk("oc_c_in1_hold", c_in1, 5);
    tick();

    // LAT=4: done four cycles after gnt; a request arriving in WAIT waits
    set_op4(1, 7, 2, 2'd3);
    req4 = 4'b0010;
    tick();
    chk("l_gnt", 32'(gnt4), 32'b0010);
    chk("l_c_mode", 32'(c_mode4), 3);
    req4 = 4'b0001;
    set_op4(0, 40, 1, 2'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("l_wait_done", 32'(done4), 0);
      chk("l_wait_gnt", 32'(gnt4), 0);
      chk("l_wait_busy", 32'(busy4), 1);
      chk("l_wait_c_in1", c_in1_4, 7);
    end
    tick();
    chk("l_done", 32'(done4), 32'b0010);
    chk("l_res", res_out4, 9);
    chk("l_z", z_out4, 5);
    chk("l_gnt_blocked", 32'(gnt4), 0);
    tick();
    chk("l_gnt_next", 32'(gnt4), 32'b0001);
    chk("l_gnt_id_next", 32'(gnt_id4), 0);
    req4 = 4'b0000;

    // reset in WAIT: op abandoned, outputs cleared, pointer back to 0
    tick();
    chk("rm_busy_pre", 32'(busy4), 1);
    nReset = 1'b0;
    tick();
    chk("rm_done", 32'(done4), 0);
    chk("rm_gnt", 32'(gnt4), 0);
    chk("rm_busy", 32'(busy4), 0);
    chk("rm_res", res_out4, 0);
    chk("rm_z", z_out4, 0);
    chk("rm_gnt_id", 32'(gnt_id4), 0);
    chk("rm_c_in1", c_in1_4, 0);
    chk("rm_state", 32'(state_dbg4), 0);
    nReset = 1'b1;
    set_op4(1, 20, 4, 2'd1);
    set_op4(2, 30, 6, 2'd2);
    req4 = 4'b0110;
    tick();
    chk("rm_gnt_after", 32'(gnt4), 32'b0010);
    req4 = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("rm_no_done", 32'(done4), 0);
    end
    tick();
    chk("rm_done_after", 32'(done4), 32'b0010);
    chk("rm_res_after", res_out4, 24);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
